// File: rtl/ex_stage_pkg.sv
// Execute-stage output bundle consumed by the memory stage; lsuop carries an lsu_t encoding.
package ex_stage_pkg;

  localparam int EX_WIDTH = 32;

  typedef struct packed {
    logic [EX_WIDTH-1:0] opr_res;
    logic [EX_WIDTH-1:0] opr_b;
    logic [4:0]          rd;
    logic [EX_WIDTH-1:0] pc4;
    logic                rf_en;
    logic                dm_en;
    logic [1:0]          wb_sel;
    logic [3:0]          lsuop;
  } ex_stage_out_t;

endpackage

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: LSU opcodes, FSM states and the writeback-facing bundle.
package mem_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LB, LH, LW, LBU, LHU, SB, SH, SW
  } lsu_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic            rf_en;
    logic [1:0]      wb_sel;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] opr_res;
    logic [XLEN-1:0] load_data;
    logic            valid;
  } mem_stage_out_t;

  function automatic logic is_store(input lsu_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, sign/zero extraction for loads and misalignment detection.
// Purely combinational; no handshake of its own.
module lsu_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  lsu_t                    lsuop,
  input  logic [1:0]              addr_lo,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    misalign
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign byte_sh = {addr_lo, 3'b000};
  assign half_sh = {addr_lo[1], 4'b0000};
  assign rbyte   = rdata[byte_sh +: 8];
  assign rhalf   = rdata[half_sh +: 16];

  always_comb begin
    be        = '0;
    wdata     = store_data;
    load_data = rdata;
    misalign  = 1'b0;
    case (lsuop)
      LB:  load_data = {{(DATA_WIDTH-8){rbyte[7]}}, rbyte};
      LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, rbyte};
      LH: begin
        misalign  = addr_lo[0];
        load_data = {{(DATA_WIDTH-16){rhalf[15]}}, rhalf};
      end
      LHU: begin
        misalign  = addr_lo[0];
        load_data = {{(DATA_WIDTH-16){1'b0}}, rhalf};
      end
      LW:  misalign = |addr_lo;
      SB: begin
        be    = (DATA_WIDTH/8)'(4'b0001 << addr_lo);
        wdata = {(DATA_WIDTH/8){store_data[7:0]}};
      end
      SH: begin
        misalign = addr_lo[0];
        be       = (DATA_WIDTH/8)'(4'b0011 << {addr_lo[1], 1'b0});
        wdata    = {(DATA_WIDTH/16){store_data[15:0]}};
      end
      SW: begin
        misalign = |addr_lo;
        be       = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: non-memory ops pass in 1 cycle, loads/stores go through a valid/ready dmem port.
// Stalls upstream from acceptance of an aligned access until its completion cycle.
module mem_stage
  import mem_stage_pkg::*;
  import ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  ex_stage_out_t           mem_stage_in,
  input  logic                    in_valid,
  output logic                    mem_stall,
  output logic                    dmem_req_valid,
  input  logic                    dmem_req_ready,
  output logic                    dmem_req_we,
  output logic [DATA_WIDTH-1:0]   dmem_req_addr,
  output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] dmem_req_be,
  input  logic                    dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   dmem_rsp_rdata,
  output mem_stage_out_t          mem_stage_out,
  output logic                    misalign
);

  state_t          state;
  lsu_t            op_q;
  logic [XLEN-1:0] opr_res_q;
  logic [XLEN-1:0] pc4_q;
  logic [4:0]      rd_q;
  logic [1:0]      wb_sel_q;
  logic            rf_en_q;

  lsu_t                    in_op;
  lsu_t                    al_op;
  logic [1:0]              al_addr_lo;
  logic [DATA_WIDTH/8-1:0] al_be;
  logic [DATA_WIDTH-1:0]   al_wdata;
  logic [DATA_WIDTH-1:0]   al_load;
  logic                    al_misalign;
  logic                    in_is_mem;
  logic                    dm_en_unused;

  assign dm_en_unused = mem_stage_in.dm_en;
  assign in_op        = lsu_t'(mem_stage_in.lsuop);
  assign in_is_mem    = (in_op != LSU_NONE);

  // In IDLE the aligner looks at the incoming op; afterwards at the latched one for load extraction.
  assign al_op      = (state == IDLE) ? in_op : op_q;
  assign al_addr_lo = (state == IDLE) ? mem_stage_in.opr_res[1:0] : opr_res_q[1:0];

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_lsu_align (
    .lsuop      (al_op),
    .addr_lo    (al_addr_lo),
    .store_data (mem_stage_in.opr_b),
    .rdata      (dmem_rsp_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misalign   (al_misalign)
  );

  always_comb begin
    mem_stall = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:     mem_stall = in_valid && in_is_mem && !al_misalign;
        REQ:      mem_stall = !(dmem_req_ready && is_store(op_q));
        WAIT_RSP: mem_stall = !dmem_rsp_valid;
        default:  mem_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= LSU_NONE;
      opr_res_q      <= '0;
      pc4_q          <= '0;
      rd_q           <= '0;
      wb_sel_q       <= '0;
      rf_en_q        <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      dmem_req_be    <= '0;
      mem_stage_out  <= '0;
      misalign       <= 1'b0;
    end else begin
      mem_stage_out.valid <= 1'b0;
      misalign            <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            opr_res_q <= mem_stage_in.opr_res;
            pc4_q     <= mem_stage_in.pc4;
            rd_q      <= mem_stage_in.rd;
            wb_sel_q  <= mem_stage_in.wb_sel;
            rf_en_q   <= mem_stage_in.rf_en;
            if (!in_is_mem || al_misalign) begin
              // Pass-through or faulting access: retire immediately, never touching memory.
              mem_stage_out.rd      <= mem_stage_in.rd;
              mem_stage_out.wb_sel  <= mem_stage_in.wb_sel;
              mem_stage_out.pc4     <= mem_stage_in.pc4;
              mem_stage_out.opr_res <= mem_stage_in.opr_res;
              mem_stage_out.rf_en   <= mem_stage_in.rf_en && !in_is_mem;
              mem_stage_out.valid   <= 1'b1;
              misalign              <= in_is_mem;
            end else begin
              state          <= REQ;
              dmem_req_valid <= 1'b1;
              dmem_req_we    <= is_store(in_op);
              dmem_req_addr  <= {mem_stage_in.opr_res[DATA_WIDTH-1:2], 2'b00};
              dmem_req_wdata <= al_wdata;
              dmem_req_be    <= al_be;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            if (is_store(op_q)) begin
              state                 <= IDLE;
              mem_stage_out.rd      <= rd_q;
              mem_stage_out.wb_sel  <= wb_sel_q;
              mem_stage_out.pc4     <= pc4_q;
              mem_stage_out.opr_res <= opr_res_q;
              mem_stage_out.rf_en   <= 1'b0;
              mem_stage_out.valid   <= 1'b1;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (dmem_rsp_valid) begin
            state                   <= IDLE;
            mem_stage_out.rd        <= rd_q;
            mem_stage_out.wb_sel    <= wb_sel_q;
            mem_stage_out.pc4       <= pc4_q;
            mem_stage_out.opr_res   <= opr_res_q;
            mem_stage_out.load_data <= al_load;
            mem_stage_out.rf_en     <= rf_en_q;
            mem_stage_out.valid     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors checked with immediate assertions.
module tb_mem_stage;
  import mem_stage_pkg::*;
  import ex_stage_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  ex_stage_out_t  mem_stage_in;
  logic           in_valid;
  logic           mem_stall;
  logic           dmem_req_valid;
  logic           dmem_req_ready;
  logic           dmem_req_we;
  logic [31:0]    dmem_req_addr;
  logic [31:0]    dmem_req_wdata;
  logic [3:0]     dmem_req_be;
  logic           dmem_rsp_valid;
  logic [31:0]    dmem_rsp_rdata;
  mem_stage_out_t mem_stage_out;
  logic           misalign;

  int n_asserts = 0;
  int n_fail    = 0;

  mem_stage #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_stage_in   (mem_stage_in),
    .in_valid       (in_valid),
    .mem_stall      (mem_stall),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_be    (dmem_req_be),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .mem_stage_out  (mem_stage_out),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_stage_out_t mk(input lsu_t op, input logic [31:0] res,
                                       input logic [31:0] b, input logic [4:0] rd,
                                       input logic rf);
    ex_stage_out_t e;
    e.opr_res = res;
    e.opr_b   = b;
    e.rd      = rd;
    e.pc4     = res + 32'd4;
    e.rf_en   = rf;
    e.dm_en   = (op != LSU_NONE);
    e.wb_sel  = (op != LSU_NONE) ? 2'd1 : 2'd0;
    e.lsuop   = op;
    return e;
  endfunction

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    mem_stage_in   = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    step();
    step();

    // Reset state
    chk("rst_valid", mem_stage_out.valid, 1'b0);
    chk("rst_rf_en", mem_stage_out.rf_en, 1'b0);
    chk("rst_req_valid", dmem_req_valid, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_opr_res", mem_stage_out.opr_res, 32'h0);
    rst_n = 1'b1;

    // ADD 0x1234 passes through in one cycle
    mem_stage_in = mk(LSU_NONE, 32'h1234, 32'h0, 5'd5, 1'b1);
    in_valid = 1'b1;
    #1 chk("add_stall", mem_stall, 1'b0);
    step();
    chk("add_valid", mem_stage_out.valid, 1'b1);
    chk("add_opr_res", mem_stage_out.opr_res, 32'h1234);
    chk("add_rd", mem_stage_out.rd, 5'd5);
    chk("add_rf_en", mem_stage_out.rf_en, 1'b1);
    chk("add_no_req", dmem_req_valid, 1'b0);
    in_valid = 1'b0;
    #1 chk("idle_stall", mem_stall, 1'b0);
    step();
    chk("idle_no_pulse", mem_stage_out.valid, 1'b0);
    chk("idle_hold_opr", mem_stage_out.opr_res, 32'h1234);

    // LB @0x1003, ready low 2 cycles, response 2 cycles after the handshake
    mem_stage_in = mk(LB, 32'h1003, 32'h0, 5'd7, 1'b1);
    in_valid = 1'b1;
    #1 chk("lb_accept_stall", mem_stall, 1'b1);
    step();
    chk("lb_req_valid0", dmem_req_valid, 1'b1);
    chk("lb_addr0", dmem_req_addr, 32'h1000);
    chk("lb_we0", dmem_req_we, 1'b0);
    chk("lb_stall0", mem_stall, 1'b1);
    step();
    chk("lb_req_valid1", dmem_req_valid, 1'b1);
    chk("lb_addr1", dmem_req_addr, 32'h1000);
    chk("lb_stall1", mem_stall, 1'b1);
    dmem_req_ready = 1'b1;
    #1 chk("lb_hs_stall", mem_stall, 1'b1);
    step();
    dmem_req_ready = 1'b0;
    chk("lb_req_dropped", dmem_req_valid, 1'b0);
    chk("lb_wait_stall", mem_stall, 1'b1);
    chk("lb_wait_no_pulse", mem_stage_out.valid, 1'b0);
    step();
    chk("lb_wait_stall2", mem_stall, 1'b1);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h80FF_FF00;
    #1 chk("lb_done_stall", mem_stall, 1'b0);
    step();
    dmem_rsp_valid = 1'b0;
    in_valid = 1'b0;
    chk("lb_valid", mem_stage_out.valid, 1'b1);
    chk("lb_load_data", mem_stage_out.load_data, 32'hFFFF_FF80);
    chk("lb_rf_en", mem_stage_out.rf_en, 1'b1);
    chk("lb_rd", mem_stage_out.rd, 5'd7);
    chk("lb_no_second_req", dmem_req_valid, 1'b0);
    step();
    chk("lb_pulse_end", mem_stage_out.valid, 1'b0);

    // SH @0x2002 data 0xABCD, ready already high
    mem_stage_in = mk(SH, 32'h2002, 32'h1234_ABCD, 5'd0, 1'b0);
    in_valid = 1'b1;
    dmem_req_ready = 1'b1;
    #1 chk("sh_accept_stall", mem_stall, 1'b1);
    step();
    chk("sh_req_valid", dmem_req_valid, 1'b1);
    chk("sh_we", dmem_req_we, 1'b1);
    chk("sh_be", dmem_req_be, 4'b1100);
    chk("sh_wdata", dmem_req_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dmem_req_addr, 32'h2000);
    chk("sh_done_stall", mem_stall, 1'b0);
    step();
    in_valid = 1'b0;
    dmem_req_ready = 1'b0;
    chk("sh_valid", mem_stage_out.valid, 1'b1);
    chk("sh_rf_en", mem_stage_out.rf_en, 1'b0);
    chk("sh_req_dropped", dmem_req_valid, 1'b0);
    step();
    chk("sh_pulse_end", mem_stage_out.valid, 1'b0);

    // LW @0x3001 is misaligned
    mem_stage_in = mk(LW, 32'h3001, 32'h0, 5'd4, 1'b1);
    in_valid = 1'b1;
    #1 chk("lw_mis_stall", mem_stall, 1'b0);
    step();
    in_valid = 1'b0;
    chk("lw_mis_flag", misalign, 1'b1);
    chk("lw_mis_valid", mem_stage_out.valid, 1'b1);
    chk("lw_mis_rf_en", mem_stage_out.rf_en, 1'b0);
    chk("lw_mis_no_req", dmem_req_valid, 1'b0);
    step();
    chk("lw_mis_pulse_end", misalign, 1'b0);
    chk("lw_mis_valid_end", mem_stage_out.valid, 1'b0);
    chk("lw_mis_still_no_req", dmem_req_valid, 1'b0);

    // Reset while waiting for a load response; late response must be dropped
    mem_stage_in = mk(LW, 32'h5000, 32'h0, 5'd6, 1'b1);
    in_valid = 1'b1;
    dmem_req_ready = 1'b1;
    step();
    step();
    chk("rw_wait_stall", mem_stall, 1'b1);
    chk("rw_wait_req", dmem_req_valid, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    dmem_req_ready = 1'b0;
    step();
    chk("rw_rst_stall", mem_stall, 1'b0);
    chk("rw_rst_valid", mem_stage_out.valid, 1'b0);
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hDEAD_BEEF;
    #1 chk("rw_late_rsp_stall", mem_stall, 1'b0);
    step();
    dmem_rsp_valid = 1'b0;
    chk("rw_late_rsp_no_pulse", mem_stage_out.valid, 1'b0);
    chk("rw_late_rsp_data", mem_stage_out.load_data, 32'h0);
    step();
    chk("rw_no_pulse2", mem_stage_out.valid, 1'b0);
    mem_stage_in = mk(LSU_NONE, 32'h55, 32'h0, 5'd2, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rw_idle_valid", mem_stage_out.valid, 1'b1);
    chk("rw_idle_opr", mem_stage_out.opr_res, 32'h55);

    // LHU @0x4002 then back-to-back ADD
    mem_stage_in = mk(LHU, 32'h4002, 32'h0, 5'd9, 1'b1);
    in_valid = 1'b1;
    dmem_req_ready = 1'b1;
    step();
    step();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h8001_0000;
    #1 chk("lhu_done_stall", mem_stall, 1'b0);
    step();
    dmem_rsp_valid = 1'b0;
    chk("lhu_valid", mem_stage_out.valid, 1'b1);
    chk("lhu_load_data", mem_stage_out.load_data, 32'h0000_8001);
    chk("lhu_rd", mem_stage_out.rd, 5'd9);
    mem_stage_in = mk(LSU_NONE, 32'h77, 32'h0, 5'd3, 1'b1);
    #1 chk("b2b_stall", mem_stall, 1'b0);
    step();
    in_valid = 1'b0;
    chk("b2b_valid", mem_stage_out.valid, 1'b1);
    chk("b2b_opr", mem_stage_out.opr_res, 32'h77);
    chk("b2b_rd", mem_stage_out.rd, 5'd3);
    chk("b2b_keeps_load", mem_stage_out.load_data, 32'h0000_8001);
    step();
    chk("b2b_pulse_end", mem_stage_out.valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
